riscv_pipeline_sequencer: RTL and testbench

// - Central stall/flush sequencer for the 5-stage RV32I pipeline; owns every pipeline-register enable and flush.
// - Combines three inputs into one consistent set of enables:
//   - the taken-branch/jump redirect (pcSrc) from the branch hazard logic;
//   - load-use hazards detected between ID and EX;
//   - a multi-cycle data-memory handshake.
// - Also provides a memory-timeout fault and stall/flush performance counters.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/riscv_load_use_detect.sv | 30 +++
 rtl/riscv_pipeline_sequencer.sv | 155 +++++++++++++++
 tb/tb_riscv_pipeline_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared encodings for the RV32I pipeline sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } seq_state_t;

    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;

endpackage

`default_nettype wire

// File: rtl/riscv_load_use_detect.sv
// ============================================================================
// Module   : riscv_load_use_detect
// Purpose  : Flags an ID instruction that reads the destination of a load in EX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_load_use_detect
    import riscv_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load into it can never be consumed
    assign o_load_use = i_ex_mem_read & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/riscv_pipeline_sequencer.sv
// ============================================================================
// Module   : riscv_pipeline_sequencer
// Purpose  : Owns all pipeline-register enables/flushes; merges redirect,
//            load-use and data-memory wait, with timeout fault and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_pipeline_sequencer
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_redirect,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_mem_wb_flush,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [TO_W-1:0]  c_TIMEOUT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0]  c_TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t        r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_fault;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_load_use;
    logic              w_mem_stall;
    logic              w_redirect_taken;
    logic [TO_W-1:0]   w_to_next;

    riscv_load_use_detect u_load_use (
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_ex_rd       (i_ex_rd),
        .i_ex_mem_read (i_ex_mem_read),
        .o_load_use    (w_load_use)
    );

    // A dropped request counts as completion, so only req without ready stalls
    assign w_mem_stall = i_mem_req & ~i_mem_ready;
    assign w_to_next   = r_to_cnt + c_TO_ONE;

    always_comb begin
        o_pc_en          = 1'b1;
        o_if_id_en       = 1'b1;
        o_if_id_flush    = 1'b0;
        o_id_ex_en       = 1'b1;
        o_id_ex_flush    = 1'b0;
        o_ex_mem_en      = 1'b1;
        o_mem_wb_en      = 1'b1;
        o_mem_wb_flush   = 1'b0;
        w_redirect_taken = 1'b0;
        if (!rst_n) begin
            w_redirect_taken = 1'b0;
        end else if (r_state == ST_FAULT) begin
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
        end else if (w_mem_stall) begin
            // EX is frozen, so any redirect/load-use re-presents after release
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
        end else if (i_ex_redirect) begin
            o_if_id_flush    = 1'b1;
            o_id_ex_flush    = 1'b1;
            w_redirect_taken = 1'b1;
        end else if (w_load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_to_cnt    <= '0;
            r_mem_fault <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!o_pc_en) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_redirect_taken) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state  <= ST_MEM_WAIT;
                        r_to_cnt <= c_TO_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state  <= ST_RUN;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= w_to_next;
                        // Counter value counts every stalled cycle including this one
                        if (w_to_next >= c_TIMEOUT) begin
                            r_mem_fault <= 1'b1;
                            r_state     <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_mem_fault = r_mem_fault;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_riscv_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_riscv_pipeline_sequencer
// Purpose  : Directed self-checking bench for the pipeline sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_pipeline_sequencer;

    localparam logic [7:0] c_NORMAL = 8'b1101_0110;
    localparam logic [7:0] c_LU     = 8'b0001_1110;
    localparam logic [7:0] c_REDIR  = 8'b1111_1110;
    localparam logic [7:0] c_MSTALL = 8'b0000_0011;
    localparam logic [7:0] c_FROZEN = 8'b0000_0000;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_en, mem_wb_flush, mem_fault;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  w_out;

    int n_vec = 0;
    int n_err = 0;

    riscv_pipeline_sequencer #(
        .MEM_TIMEOUT (4),
        .TO_W        (8),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_redirect  (ex_redirect),
        .i_mem_req      (mem_req),
        .i_mem_ready    (mem_ready),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_en    (mem_wb_en),
        .o_mem_wb_flush (mem_wb_flush),
        .o_mem_fault    (mem_fault),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    assign w_out = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, mem_wb_en, mem_wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_vec(tag, {24'd0, w_out}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_lw_x5_add(input logic via_rs2);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = via_rs2 ? 5'd1 : 5'd5; id_use_rs1 = 1'b1;
        id_rs2 = via_rs2 ? 5'd5 : 5'd1; id_use_rs2 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check_vec("rst_out",   {24'd0, w_out}, {24'd0, c_NORMAL});
        check_vec("rst_fault", {31'd0, mem_fault}, 32'd0);
        check_vec("rst_stall", stall_cnt, 32'd0);
        check_vec("rst_flush", flush_cnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use through rs1, then released
        set_lw_x5_add(1'b0);
        cyc("lu_rs1", c_LU);
        idle();
        cyc("lu_release", c_NORMAL);
        check_vec("lu_stall_cnt", stall_cnt, 32'd1);

        // x0 and non-use cases never stall
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc("x0_no_stall", c_NORMAL);
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
        cyc("nouse_no_stall", c_NORMAL);
        set_lw_x5_add(1'b1);
        cyc("lu_rs2", c_LU);
        idle();
        check_vec("lu2_stall_cnt", stall_cnt, 32'd2);

        // Redirect wins over load-use
        set_lw_x5_add(1'b0);
        ex_redirect = 1'b1;
        cyc("redir_over_lu", c_REDIR);
        idle();
        check_vec("redir_flush_cnt", flush_cnt, 32'd1);
        check_vec("redir_stall_cnt", stall_cnt, 32'd2);

        // Memory wait: three stalled cycles, release in the fourth
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mwait", c_MSTALL);
        mem_ready = 1'b1;
        cyc("mwait_release", c_NORMAL);
        idle();
        check_vec("mwait_stall_cnt", stall_cnt, 32'd5);
        check_vec("mwait_no_fault", {31'd0, mem_fault}, 32'd0);

        // Redirect held during wait appears only in the release cycle
        mem_req = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mwait_redir", c_MSTALL);
        mem_ready = 1'b1;
        cyc("mwait_redir_release", c_REDIR);
        idle();
        check_vec("mwait_redir_flush_cnt", flush_cnt, 32'd2);
        check_vec("mwait_redir_stall_cnt", stall_cnt, 32'd8);

        // Request dropped mid-wait counts as ready
        mem_req = 1'b1;
        cyc("drop_wait", c_MSTALL);
        mem_req = 1'b0;
        cyc("drop_release", c_NORMAL);
        cyc("drop_run", c_NORMAL);
        check_vec("drop_no_fault", {31'd0, mem_fault}, 32'd0);

        // Timeout after four stalled cycles
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("to_wait", c_MSTALL);
            if (i < 3) check_vec("to_pre_fault", {31'd0, mem_fault}, 32'd0);
        end
        check_vec("to_fault_set", {31'd0, mem_fault}, 32'd1);
        check_vec("to_stall_cnt", stall_cnt, 32'd13);
        mem_ready = 1'b1; ex_redirect = 1'b1;
        cyc("fault_hold", c_FROZEN);
        cyc("fault_hold2", c_FROZEN);
        check_vec("fault_stall_cnt", stall_cnt, 32'd15);
        check_vec("fault_sticky", {31'd0, mem_fault}, 32'd1);

        // Reset restores RUN and clears everything
        idle();
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check_vec("rst2_fault", {31'd0, mem_fault}, 32'd0);
        check_vec("rst2_stall", stall_cnt, 32'd0);
        check_vec("rst2_flush", flush_cnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc("rst2_run", c_NORMAL);
        check_vec("rst2_stall_after", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
